pd_dw_lte_rdout: RTL and testbench

Readout engine for the LTE downlink power-detection result RAM. The calc stage fills this RAM with 48-bit accumulated I²+Q² values at address {symbol[7:0], sub[2:0]}, 140 symbols × 8 subs per frame. This block scans that RAM after a frame completes and streams every entry out on a valid/ready interface, together with a per-symbol total. It sits between the RAM read port and the PD report/AGC consumer.

---
 rtl/pd_dw_lte_rdout.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_pd_dw_lte_rdout.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_dw_lte_rdout.sv
// -----------------------------------------------------------------------------
// pd_dw_lte_rdout
//
// Readout engine for the LTE downlink power-detection result RAM. After the
// calc stage signals a completed frame (i_start), the block walks the RAM in
// address order {symb[7:0], sub[2:0]} and streams every 48-bit I^2+Q^2 value
// on a valid/ready interface. Every beat carries its symbol/sub index. The
// last beat of each symbol also carries the 51-bit sum of that symbol's
// N_SUB values.
//
// Data path:  address counter -> RAM (RD_LAT) -> skid FIFO -> output register
// RAM reads are credit-limited so that every in-flight read has a FIFO slot
// reserved. A back-pressured consumer therefore never causes loss.
//
// Ports:
//   sys_clk      clock
//   sys_rst      synchronous active-high reset
//   i_start      one-cycle pulse: frame results complete, begin readout
//   o_busy       high from accepted start until the last beat is accepted
//   o_rd_en      RAM read strobe
//   o_rd_addr    RAM read address {symb, sub}
//   i_rd_data    RAM read data, valid RD_LAT cycles after o_rd_en
//   o_valid      output beat valid
//   i_ready      consumer ready; beat accepted on o_valid & i_ready
//   o_data       power value of the beat
//   o_symb       symbol index of the beat
//   o_sub        sub index of the beat
//   o_symb_end   beat is the last sub of its symbol
//   o_symb_pwr   sum of the symbol's values when o_symb_end=1, else 0
//   o_last       beat is the final entry of the frame
//   o_done       one-cycle pulse after the o_last beat is accepted
// -----------------------------------------------------------------------------
module pd_dw_lte_rdout #(
  parameter int N_SYMB     = 140,
  parameter int N_SUB      = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_rd_en,
  output logic [10:0] o_rd_addr,
  input  logic [47:0] i_rd_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [47:0] o_data,
  output logic [7:0]  o_symb,
  output logic [2:0]  o_sub,
  output logic        o_symb_end,
  output logic [50:0] o_symb_pwr,
  output logic        o_last,
  output logic        o_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // Wide enough for (in-flight reads + FIFO occupancy).
  localparam int OUT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

  // Per-beat side information, computed when the address is issued.
  typedef struct packed {
    logic [7:0] symb;
    logic [2:0] sub;
    logic       symb_end;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [47:0] data;
    tag_t        tag;
  } beat_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [7:0]           symb_q;
  logic [2:0]           sub_q;
  logic                 issue_last;
  tag_t                 issue_tag;
  logic                 rd_en;

  logic [RD_LAT-1:0]    vld_sr;
  tag_t                 tag_sr [RD_LAT];
  logic                 ret_vld;
  beat_t                ret_beat;
  logic [OUT_W-1:0]     inflight;
  logic [OUT_W-1:0]     outstanding;

  beat_t                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 bypass;

  beat_t                out_q;
  logic                 out_vld;
  logic                 out_take;
  logic                 accept;

  logic [50:0]          acc_q;
  logic [50:0]          sum_now;
  logic                 done_q;

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start)                      state_d = S_READ;
      S_READ:  if (rd_en && issue_last)          state_d = S_DRAIN;
      S_DRAIN: if (accept && out_q.tag.last)     state_d = S_IDLE;
      default:                                   state_d = S_IDLE;
    endcase
  end

  // A read is issued only when a FIFO slot can be reserved for its return.
  always_comb begin
    o_busy = (state_q != S_IDLE);
    rd_en  = (state_q == S_READ) && (outstanding < OUT_W'(FIFO_DEPTH));
  end

  assign o_rd_en = rd_en;

  // ---------------------------------------------------------------------------
  // Address counters: sub wraps and carries into symb; the counter parks on
  // the final address instead of advancing past it.
  // ---------------------------------------------------------------------------
  assign issue_last = (symb_q == 8'(N_SYMB - 1)) && (sub_q == 3'(N_SUB - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || state_q == S_IDLE) begin
      symb_q <= '0;
      sub_q  <= '0;
    end else if (rd_en && !issue_last) begin
      if (sub_q == 3'(N_SUB - 1)) begin
        sub_q  <= '0;
        symb_q <= symb_q + 1'b1;
      end else begin
        sub_q  <= sub_q + 1'b1;
      end
    end
  end

  assign o_rd_addr = {symb_q, sub_q};

  always_comb begin
    issue_tag          = '0;
    issue_tag.symb     = symb_q;
    issue_tag.sub      = sub_q;
    issue_tag.symb_end = (sub_q == 3'(N_SUB - 1));
    issue_tag.last     = issue_last;
  end

  // ---------------------------------------------------------------------------
  // Read-return tracking. The valid shift register is reset so that reads in
  // flight at reset are discarded; the tags travel alongside it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  // NOTE: tag and FIFO storage carry no reset; their contents only matter
  // when qualified by vld_sr / fifo_cnt, which are reset.
  always_ff @(posedge sys_clk) begin
    tag_sr[0] <= issue_tag;
    for (int i = 1; i < RD_LAT; i++) tag_sr[i] <= tag_sr[i-1];
  end

  assign ret_vld = vld_sr[RD_LAT-1];

  always_comb begin
    ret_beat      = '0;
    ret_beat.data = i_rd_data;
    ret_beat.tag  = tag_sr[RD_LAT-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OUT_W'(vld_sr[i]);
  end

  assign outstanding = inflight + OUT_W'(fifo_cnt);

  // ---------------------------------------------------------------------------
  // Skid FIFO. Returning data bypasses straight into the output register when
  // the FIFO is empty and the register can take it; otherwise it queues
  // behind older entries so ordering is preserved.
  // ---------------------------------------------------------------------------
  assign fifo_empty = (fifo_cnt == '0);
  assign accept     = out_vld && i_ready;
  assign out_take   = !out_vld || i_ready;
  assign fifo_pop   = out_take && !fifo_empty;
  assign bypass     = out_take && fifo_empty && ret_vld;
  assign fifo_push  = ret_vld && !bypass;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= ret_beat;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Credits guarantee a slot for every return.
  a_fifo_no_overflow: assert property (@(posedge sys_clk) disable iff (sys_rst)
    (fifo_push && !fifo_pop) |-> (fifo_cnt < CNT_W'(FIFO_DEPTH)));

  // ---------------------------------------------------------------------------
  // Output register: holds the beat until accepted. Fields are cleared when
  // no beat is presented, so an idle interface reads as all zeros.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (out_take) begin
      if (!fifo_empty) begin
        out_vld <= 1'b1;
        out_q   <= fifo_mem[rd_ptr];
      end else if (ret_vld) begin
        out_vld <= 1'b1;
        out_q   <= ret_beat;
      end else begin
        out_vld <= 1'b0;
        out_q   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Symbol power: the accumulator holds the sum of the accepted beats of the
  // current symbol; the symbol-end beat presents accumulator + its own data.
  // 8 x (2^48-1) fits in 51 bits, so no saturation is needed.
  // ---------------------------------------------------------------------------
  assign sum_now = acc_q + {3'b000, out_q.data};

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                acc_q <= '0;
    else if (accept) begin
      if (out_q.tag.symb_end)   acc_q <= '0;
      else                      acc_q <= sum_now;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) done_q <= 1'b0;
    else         done_q <= accept && out_q.tag.last;
  end

  assign o_valid    = out_vld;
  assign o_data     = out_q.data;
  assign o_symb     = out_q.tag.symb;
  assign o_sub      = out_q.tag.sub;
  assign o_symb_end = out_q.tag.symb_end;
  assign o_last     = out_q.tag.last;
  assign o_symb_pwr = out_q.tag.symb_end ? sum_now : '0;
  assign o_done     = done_q;

endmodule

// File: tb/tb_pd_dw_lte_rdout.sv
// -----------------------------------------------------------------------------
// tb_pd_dw_lte_rdout
//
// Four instances of pd_dw_lte_rdout, each with its own RAM model:
//   0: RD_LAT=2, N_SYMB=140     1: RD_LAT=1, N_SYMB=140
//   2: RD_LAT=3, N_SYMB=140     3: RD_LAT=2, N_SYMB=2
// The RAM returns addr*3, or 2^48-1 for every entry when ones_mode is set.
// Expected beats are derived from the beat index: data = 3k (or all ones),
// symb = k/8, sub = k%8, symbol sum = 3*(64s+28) = 192s+84 (or 8*(2^48-1)).
// -----------------------------------------------------------------------------
module tb_pd_dw_lte_rdout;

  localparam int NI = 4;

  logic sys_clk = 1'b0;
  logic sys_rst;
  bit   ones_mode;
  int   tests_run;
  int   tests_failed;

  always #2 sys_clk = ~sys_clk;

  logic        start    [NI];
  logic        ready    [NI];
  logic        busy     [NI];
  logic        rd_en    [NI];
  logic [10:0] rd_addr  [NI];
  logic [47:0] rd_data  [NI];
  logic        valid    [NI];
  logic [47:0] data     [NI];
  logic [7:0]  symb     [NI];
  logic [2:0]  sub      [NI];
  logic        symb_end [NI];
  logic [50:0] pwr      [NI];
  logic        last     [NI];
  logic        done     [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
      localparam int NS  = (g == 3) ? 2 : 140;

      logic [10:0] apipe [LAT];

      always @(posedge sys_clk) begin
        apipe[0] <= rd_addr[g];
        for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
      end

      assign rd_data[g] = ones_mode ? 48'hFFFF_FFFF_FFFF : 48'(apipe[LAT-1]) * 48'd3;

      pd_dw_lte_rdout #(
        .N_SYMB     (NS),
        .N_SUB      (8),
        .RD_LAT     (LAT),
        .FIFO_DEPTH (4)
      ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .i_start    (start[g]),
        .o_busy     (busy[g]),
        .o_rd_en    (rd_en[g]),
        .o_rd_addr  (rd_addr[g]),
        .i_rd_data  (rd_data[g]),
        .o_valid    (valid[g]),
        .i_ready    (ready[g]),
        .o_data     (data[g]),
        .o_symb     (symb[g]),
        .o_sub      (sub[g]),
        .o_symb_end (symb_end[g]),
        .o_symb_pwr (pwr[g]),
        .o_last     (last[g]),
        .o_done     (done[g])
      );
    end
  endgenerate

  function automatic logic [126:0] outs_of(input int i);
    return {busy[i], rd_en[i], rd_addr[i], valid[i], data[i], symb[i], sub[i],
            symb_end[i], pwr[i], last[i], done[i]};
  endfunction

  // One full readout on instance i. rnd: random i_ready plus a 30-cycle stall.
  // spam: re-pulse i_start while busy. abort_at>0: reset after that many beats.
  task automatic run_frame(input int i, input int nsymb, input int lat, input bit rnd,
                           input bit spam, input int abort_at, input string name);
    int          beats, cyc, first_v, done_cnt, done_cyc_exp, addr_bad, tail_bad, stray;
    bit          finished, aborted, r, hold;
    logic [47:0] p_data;
    logic [7:0]  p_symb;
    logic [2:0]  p_sub;
    logic        p_end, p_last;
    logic [50:0] p_pwr;
    logic [47:0] exp_data;
    logic        exp_end, exp_last;
    logic [50:0] exp_pwr;

    beats = 0; cyc = 0; first_v = -1; done_cnt = 0; done_cyc_exp = -1;
    addr_bad = 0; finished = 0; aborted = 0; hold = 0;
    p_data = '0; p_symb = '0; p_sub = '0; p_end = 0; p_last = 0; p_pwr = '0;

    @(negedge sys_clk);
    start[i] = 1'b1;
    ready[i] = 1'b1;
    @(negedge sys_clk);
    start[i] = 1'b0;
    cyc = 1;

    while (!finished && !aborted && cyc < 8000) begin
      if (cyc == 1) begin
        tests_run++;
        if ({rd_en[i], busy[i]} !== 2'b11) begin
          tests_failed++;
          $display("FAIL %s first_read: rd_en=%b busy=%b, want 1 1", name, rd_en[i], busy[i]);
        end
      end
      if (valid[i] && first_v < 0) first_v = cyc;
      if (rd_en[i] && rd_addr[i] >= 11'(nsymb * 8)) addr_bad++;

      if (hold) begin
        tests_run++;
        if ({valid[i], data[i], symb[i], sub[i], symb_end[i], pwr[i], last[i]} !==
            {1'b1, p_data, p_symb, p_sub, p_end, p_pwr, p_last}) begin
          tests_failed++;
          $display("FAIL %s stall_hold cyc %0d: valid=%b data=%h, want 1 %h", name, cyc,
                   valid[i], data[i], p_data);
        end
      end

      if (done[i]) begin
        done_cnt++;
        finished = 1;
        start[i] = 1'b0;
        tests_run++;
        if (cyc != done_cyc_exp || busy[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s done_timing: done at cyc %0d busy=%b, want cyc %0d busy 0", name,
                   cyc, busy[i], done_cyc_exp);
        end
      end

      if (!finished) begin
        r = rnd ? ((cyc >= 200 && cyc < 230) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
        ready[i] = r;
        start[i] = (spam && busy[i] && (cyc % 29 == 0));

        if (valid[i] && r) begin
          exp_data = ones_mode ? 48'hFFFF_FFFF_FFFF : 48'(beats * 3);
          exp_end  = (beats % 8 == 7);
          exp_pwr  = !exp_end ? 51'd0 :
                     (ones_mode ? 51'h7_FFFF_FFFF_FFF8 : 51'(192 * (beats / 8) + 84));
          exp_last = (beats == nsymb * 8 - 1);
          tests_run++;
          if ({data[i], symb[i], sub[i], symb_end[i], pwr[i], last[i]} !==
              {exp_data, 8'(beats / 8), 3'(beats % 8), exp_end, exp_pwr, exp_last}) begin
            tests_failed++;
            $display("FAIL %s beat %0d: data=%h symb=%0d sub=%0d end=%b pwr=%h last=%b, want data=%h symb=%0d sub=%0d end=%b pwr=%h last=%b",
                     name, beats, data[i], symb[i], sub[i], symb_end[i], pwr[i], last[i],
                     exp_data, beats / 8, beats % 8, exp_end, exp_pwr, exp_last);
          end
          if (last[i]) done_cyc_exp = cyc + 1;
          beats++;
          if (beats == abort_at) begin
            sys_rst = 1'b1;
            aborted = 1;
          end
        end

        hold   = valid[i] && !r;
        p_data = data[i]; p_symb = symb[i]; p_sub = sub[i];
        p_end  = symb_end[i]; p_pwr = pwr[i]; p_last = last[i];
      end

      if (!finished && !aborted) begin
        @(negedge sys_clk);
        cyc++;
      end
    end

    if (aborted) begin
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      start[i] = 1'b0;
      ready[i] = 1'b1;
      tests_run++;
      if (outs_of(i) !== '0) begin
        tests_failed++;
        $display("FAIL %s reset_outputs: outputs=%h, want 0", name, outs_of(i));
      end
      stray = 0;
      repeat (10) begin
        @(negedge sys_clk);
        if (valid[i] || rd_en[i] || done[i] || busy[i]) stray++;
      end
      tests_run++;
      if (stray != 0) begin
        tests_failed++;
        $display("FAIL %s post_reset_stray: %0d active cycles, want 0", name, stray);
      end
    end else begin
      start[i] = 1'b0;
      ready[i] = 1'b1;
      tests_run++;
      if (!finished) begin
        tests_failed++;
        $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
      end
      tests_run++;
      if (beats != nsymb * 8) begin
        tests_failed++;
        $display("FAIL %s beat_count: got %0d, want %0d", name, beats, nsymb * 8);
      end
      tests_run++;
      if (first_v != lat + 2) begin
        tests_failed++;
        $display("FAIL %s first_valid_latency: got %0d, want %0d", name, first_v, lat + 2);
      end
      tests_run++;
      if (addr_bad != 0) begin
        tests_failed++;
        $display("FAIL %s addr_range: %0d reads at or past %0d", name, addr_bad, nsymb * 8);
      end
      tail_bad = 0;
      repeat (20) begin
        @(negedge sys_clk);
        if (done[i]) done_cnt++;
        if (valid[i] || busy[i] || rd_en[i]) tail_bad++;
      end
      tests_run++;
      if (tail_bad != 0 || done_cnt != 1) begin
        tests_failed++;
        $display("FAIL %s idle_after: active=%0d done_pulses=%0d, want 0 and 1", name,
                 tail_bad, done_cnt);
      end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b1;  // start together with reset: reset must win
      ready[i] = 1'b0;
    end
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < NI; i++) start[i] = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (outs_of(i) !== '0) begin
        tests_failed++;
        $display("FAIL reset_state inst %0d: outputs=%h, want 0", i, outs_of(i));
      end
    end
  endtask

  task automatic test_linear();
    run_frame(0, 140, 2, 1'b0, 1'b0, 0, "linear");
  endtask

  task automatic test_random_ready();
    run_frame(0, 140, 2, 1'b1, 1'b0, 0, "rnd_lat2");
    run_frame(1, 140, 1, 1'b1, 1'b0, 0, "rnd_lat1");
    run_frame(2, 140, 3, 1'b1, 1'b0, 0, "rnd_lat3");
  endtask

  task automatic test_saturate();
    ones_mode = 1'b1;
    run_frame(0, 140, 2, 1'b1, 1'b0, 0, "all_ones");
    ones_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_frame(0, 140, 2, 1'b0, 1'b0, 500, "abort500");
    run_frame(0, 140, 2, 1'b0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_start_spam();
    run_frame(0, 140, 2, 1'b1, 1'b1, 0, "start_spam");
  endtask

  task automatic test_short_frame();
    run_frame(3, 2, 2, 1'b0, 1'b0, 0, "nsymb2");
    run_frame(3, 2, 2, 1'b1, 1'b0, 0, "nsymb2_rnd");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ones_mode    = 1'b0;
    sys_rst      = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      ready[i] = 1'b0;
    end
    test_reset();
    test_linear();
    test_random_ready();
    test_saturate();
    test_reset_mid();
    test_start_spam();
    test_short_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
